// File: rtl/store_checker.sv
// Store scoreboard for the single-cycle MIPS core: compares each data-memory
// store, in order, against a preloaded FIFO of expected stores and latches a verdict.
module store_checker #(
    parameter int DEPTH   = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_valid,
    input  logic [AW-1:0] exp_addr,
    input  logic [DW-1:0] exp_data,
    output logic          exp_ready,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [15:0]   match_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CODE_EXTRA    = 2'd3;

    logic [1:0]    r_state;
    logic [PW:0]   r_wrPtr;
    logic [PW:0]   r_rdPtr;
    logic [AW-1:0] r_memAddr [DEPTH];
    logic [DW-1:0] r_memData [DEPTH];
    logic [IW-1:0] r_idle;
    logic [1:0]    r_failCode;
    logic [AW-1:0] r_failAddr;
    logic [DW-1:0] r_failData;
    logic [15:0]   r_matchCount;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_headMatch;
    logic          w_match;
    logic          w_lastPop;

    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    assign w_full      = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    assign w_empty     = (r_wrPtr == r_rdPtr);
    assign w_push      = (r_state == S_LOAD) && exp_valid && !w_full;
    assign w_headMatch = (dataadr == r_memAddr[r_rdPtr[PW-1:0]]) &&
                         (writedata == r_memData[r_rdPtr[PW-1:0]]);
    assign w_match     = (r_state == S_RUN) && memwrite && w_headMatch;
    assign w_lastPop   = ((r_rdPtr + (PW+1)'(1)) == r_wrPtr);

    assign exp_ready   = (r_state == S_LOAD) && !w_full;
    assign pass        = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign done        = pass | fail;
    assign fail_code   = r_failCode;
    assign fail_addr   = r_failAddr;
    assign fail_data   = r_failData;
    assign match_count = r_matchCount;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memAddr[r_wrPtr[PW-1:0]] <= exp_addr;
            r_memData[r_wrPtr[PW-1:0]] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (PW+1)'(1);
            end
            if (w_match) begin
                r_rdPtr <= r_rdPtr + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LOAD;
            r_idle       <= '0;
            r_failCode   <= '0;
            r_failAddr   <= '0;
            r_failData   <= '0;
            r_matchCount <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_idle <= '0;
                    // A push in the start cycle still counts, so only a truly empty list passes.
                    if (start) begin
                        r_state <= (w_empty && !w_push) ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    if (memwrite) begin
                        if (w_headMatch) begin
                            r_idle <= '0;
                            if (r_matchCount != 16'hFFFF) begin
                                r_matchCount <= r_matchCount + 16'd1;
                            end
                            if (w_lastPop) begin
                                r_state <= S_PASS;
                            end
                        end else begin
                            r_state    <= S_FAIL;
                            r_failCode <= CODE_MISMATCH;
                            r_failAddr <= dataadr;
                            r_failData <= writedata;
                        end
                    end else if (r_idle == IW'(TIMEOUT - 1)) begin
                        r_state    <= S_FAIL;
                        r_failCode <= CODE_TIMEOUT;
                    end else begin
                        r_idle <= r_idle + IW'(1);
                    end
                end
                S_PASS: begin
                    if (memwrite) begin
                        r_state    <= S_FAIL;
                        r_failCode <= CODE_EXTRA;
                        r_failAddr <= dataadr;
                        r_failData <= writedata;
                    end
                end
                default: begin
                    r_state <= S_FAIL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// Directed self-checking bench for store_checker (DEPTH 8, TIMEOUT 16).
module tb_store_checker;

    logic        clk;
    logic        reset;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;
    logic [15:0] match_count;

    int checkCount;
    int failCount;

    store_checker #(
        .DEPTH(8), .AW(32), .DW(32), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(exp_ready),
        .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_addr(fail_addr), .fail_data(fail_data), .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, then lands 1 ns after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ea, input logic [31:0] ed,
                                 input logic st, input logic mw, input logic [31:0] a,
                                 input logic [31:0] d);
        exp_valid = v;  exp_addr = ea; exp_data = ed;
        start = st;     memwrite = mw; dataadr = a;  writedata = d;
        @(posedge clk);
        #1;
        exp_valid = 1'b0; start = 1'b0; memwrite = 1'b0;
    endtask

    task automatic pushEntry(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, a, d);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset = 1'b0; exp_valid = 1'b0; exp_addr = '0; exp_data = '0;
        start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;

        #2;
        checkOutput("rst_exp_ready", 32'(exp_ready), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_fail_code", 32'(fail_code), 32'd0);
        checkOutput("rst_match", 32'(match_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single store that matches.
        pushEntry(32'd84, 32'd7);
        pulseStart();
        checkOutput("t1_run_ready", 32'(exp_ready), 32'd0);
        checkOutput("t1_run_done", 32'(done), 32'd0);
        doStore(32'd84, 32'd7);
        checkOutput("t1_pass", 32'(pass), 32'd1);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_match", 32'(match_count), 32'd1);
        checkOutput("t1_code", 32'(fail_code), 32'd0);

        // Data mismatch, then FAIL must hold its captures.
        pulseReset();
        pushEntry(32'd84, 32'd7);
        pulseStart();
        doStore(32'd84, 32'd6);
        checkOutput("t2_fail", 32'(fail), 32'd1);
        checkOutput("t2_code", 32'(fail_code), 32'd1);
        checkOutput("t2_addr", fail_addr, 32'd84);
        checkOutput("t2_data", fail_data, 32'd6);
        checkOutput("t2_match", 32'(match_count), 32'd0);
        doStore(32'd99, 32'd98);
        checkOutput("t2_hold_addr", fail_addr, 32'd84);
        checkOutput("t2_hold_fail", 32'(fail), 32'd1);

        // In-order back-to-back stores.
        pulseReset();
        pushEntry(32'h50, 32'd1);
        pushEntry(32'h54, 32'd2);
        pushEntry(32'h58, 32'd3);
        pulseStart();
        doStore(32'h50, 32'd1);
        doStore(32'h54, 32'd2);
        checkOutput("t3_mid_match", 32'(match_count), 32'd2);
        checkOutput("t3_mid_pass", 32'(pass), 32'd0);
        doStore(32'h58, 32'd3);
        checkOutput("t3_pass", 32'(pass), 32'd1);
        checkOutput("t3_match", 32'(match_count), 32'd3);

        // Out-of-order store.
        pulseReset();
        pushEntry(32'h50, 32'd1);
        pushEntry(32'h54, 32'd2);
        pushEntry(32'h58, 32'd3);
        pulseStart();
        doStore(32'h50, 32'd1);
        doStore(32'h58, 32'd3);
        checkOutput("t3b_fail", 32'(fail), 32'd1);
        checkOutput("t3b_code", 32'(fail_code), 32'd1);
        checkOutput("t3b_addr", fail_addr, 32'h58);
        checkOutput("t3b_data", fail_data, 32'd3);
        checkOutput("t3b_match", 32'(match_count), 32'd1);

        // Timeout: 16th idle edge in RUN fails, not the 15th.
        pulseReset();
        pushEntry(32'h10, 32'h20);
        pulseStart();
        for (int i = 0; i < 15; i++) idleCycle();
        checkOutput("t4_not_yet", 32'(fail), 32'd0);
        idleCycle();
        checkOutput("t4_fail", 32'(fail), 32'd1);
        checkOutput("t4_code", 32'(fail_code), 32'd2);
        checkOutput("t4_addr", fail_addr, 32'd0);
        checkOutput("t4_data", fail_data, 32'd0);

        // Full FIFO, rejected 9th push, then an extra store after PASS.
        pulseReset();
        for (int i = 0; i < 7; i++) pushEntry(32'h100 + 32'(4 * i), 32'(i + 1));
        checkOutput("t5_ready7", 32'(exp_ready), 32'd1);
        pushEntry(32'h11C, 32'd8);
        checkOutput("t5_ready8", 32'(exp_ready), 32'd0);
        pushEntry(32'hDEAD, 32'hBEEF);
        pulseStart();
        for (int i = 0; i < 8; i++) doStore(32'h100 + 32'(4 * i), 32'(i + 1));
        checkOutput("t5_pass", 32'(pass), 32'd1);
        checkOutput("t5_match", 32'(match_count), 32'd8);
        doStore(32'h200, 32'h55);
        checkOutput("t5_fail", 32'(fail), 32'd1);
        checkOutput("t5_pass_drop", 32'(pass), 32'd0);
        checkOutput("t5_code", 32'(fail_code), 32'd3);
        checkOutput("t5_addr", fail_addr, 32'h200);
        checkOutput("t5_data", fail_data, 32'h55);

        // Asynchronous reset after two of three matches.
        pulseReset();
        pushEntry(32'h50, 32'd1);
        pushEntry(32'h54, 32'd2);
        pushEntry(32'h58, 32'd3);
        pulseStart();
        doStore(32'h50, 32'd1);
        doStore(32'h54, 32'd2);
        checkOutput("t6_pre_match", 32'(match_count), 32'd2);
        reset = 1'b0;
        #2;
        checkOutput("t6_async_ready", 32'(exp_ready), 32'd1);
        checkOutput("t6_async_match", 32'(match_count), 32'd0);
        checkOutput("t6_async_done", 32'(done), 32'd0);
        checkOutput("t6_async_code", 32'(fail_code), 32'd0);
        reset = 1'b1;
        #1;
        pulseStart();
        checkOutput("t6_empty_pass", 32'(pass), 32'd1);
        checkOutput("t6_empty_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
